// File: rtl/pll_reconfig_responder.sv
// Avalon-MM responder for the video PLL reconfig port: shadow M/N/C/bw/cp
// registers applied atomically through a reset / apply / lock-wait sequence.
module pll_reconfig_responder #(
  parameter int RESET_CYCLES = 4,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_read,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic        pll_reset,
  output logic        pll_locked,
  output logic [9:0]  m_div,
  output logic [9:0]  n_div,
  output logic [9:0]  c_div,
  output logic [3:0]  bw_cfg,
  output logic [2:0]  cp_cfg
);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_APPLY, S_LOCK} state_t;

  localparam int          CW        = 16;
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [17:0] CNT_RST   = 18'h1_0000;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [17:0]   n_q, n_d, m_q, m_d, c_q, c_d;
  logic [3:0]    bw_q, bw_d;
  logic [2:0]    cp_q, cp_d;
  logic [17:0]   an_q, an_d, am_q, am_d, ac_q, ac_d;
  logic [3:0]    abw_q, abw_d;
  logic [2:0]    acp_q, acp_d;

  logic busy, wr_en, start_req;

  // Field value 0 encodes 256; the odd bit never changes the divide value.
  function automatic logic [9:0] div_decode(input logic [17:0] r);
    logic [9:0] hi, lo;
    hi = (r[15:8] == 8'd0) ? 10'd256 : {2'b00, r[15:8]};
    lo = (r[7:0]  == 8'd0) ? 10'd256 : {2'b00, r[7:0]};
    return r[16] ? 10'd1 : (hi + lo);
  endfunction

  assign busy             = (state_q != S_IDLE);
  assign mgmt_waitrequest = ~mode_q & busy & (mgmt_read | mgmt_write);
  assign wr_en            = mgmt_write & ~mgmt_waitrequest;
  assign start_req        = wr_en && (mgmt_address == 6'd2) && mgmt_writedata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      n_q     <= CNT_RST;
      m_q     <= CNT_RST;
      c_q     <= CNT_RST;
      bw_q    <= 4'd6;
      cp_q    <= 3'd3;
      an_q    <= CNT_RST;
      am_q    <= CNT_RST;
      ac_q    <= CNT_RST;
      abw_q   <= 4'd6;
      acp_q   <= 3'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c_q     <= c_d;
      bw_q    <= bw_d;
      cp_q    <= cp_d;
      an_q    <= an_d;
      am_q    <= am_d;
      ac_q    <= ac_d;
      abw_q   <= abw_d;
      acp_q   <= acp_d;
    end
  end

  // Start is only honoured from IDLE, so busy-time starts fall through.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start_req) begin
        state_d = S_RST;
        cnt_d   = '0;
      end
      S_RST: if (cnt_q == RST_LAST) state_d = S_APPLY;
             else                   cnt_d   = cnt_q + 1'b1;
      S_APPLY: begin
        state_d = S_LOCK;
        cnt_d   = '0;
      end
      S_LOCK: if (cnt_q == LOCK_LAST) state_d = S_IDLE;
              else                    cnt_d   = cnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    n_d    = n_q;
    m_d    = m_q;
    c_d    = c_q;
    bw_d   = bw_q;
    cp_d   = cp_q;
    if (wr_en) begin
      unique case (mgmt_address)
        6'd0: mode_d = mgmt_writedata[0];
        6'd3: n_d    = mgmt_writedata[17:0];
        6'd4: m_d    = mgmt_writedata[17:0];
        6'd5: c_d    = mgmt_writedata[17:0];
        6'd8: bw_d   = mgmt_writedata[3:0];
        6'd9: cp_d   = mgmt_writedata[2:0];
        default: ;
      endcase
    end
  end

  // Apply uses the pre-edge shadows; a same-cycle write only hits the shadow.
  always_comb begin
    an_d  = an_q;
    am_d  = am_q;
    ac_d  = ac_q;
    abw_d = abw_q;
    acp_d = acp_q;
    if (state_q == S_APPLY) begin
      an_d  = n_q;
      am_d  = m_q;
      ac_d  = c_q;
      abw_d = bw_q;
      acp_d = cp_q;
    end
  end

  always_comb begin
    pll_reset  = (state_q == S_RST);
    pll_locked = (state_q == S_IDLE);
    m_div      = div_decode(am_q);
    n_div      = div_decode(an_q);
    c_div      = div_decode(ac_q);
    bw_cfg     = abw_q;
    cp_cfg     = acp_q;
  end

  always_comb begin
    mgmt_readdata = '0;
    unique case (mgmt_address)
      6'd0: mgmt_readdata = {31'd0, mode_q};
      6'd1: mgmt_readdata = {31'd0, ~busy};
      6'd3: mgmt_readdata = {14'd0, n_q};
      6'd4: mgmt_readdata = {14'd0, m_q};
      6'd5: mgmt_readdata = {14'd0, c_q};
      6'd8: mgmt_readdata = {28'd0, bw_q};
      6'd9: mgmt_readdata = {29'd0, cp_q};
      default: ;
    endcase
  end

endmodule
